// File: rtl/instruction_fetch.sv
// instruction_fetch
// Fetch stage of the 19-bit processor. Owns the program counter, presents it
// to the combinational instruction memory, and captures the returned word
// into the IF/ID pipeline register for decode. Absolute JMP words are
// predecoded here so the jump costs no bubble. Taken branches arrive from
// downstream as a redirect.
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   start               pulse: leave IDLE/HALT and fetch from the current pc
//   halt                level: stop fetching at the next edge
//   stall               hold pc and IF/ID (hazard from later stages)
//   redirect_valid/
//   redirect_target     taken branch; load pc with the target
//   imem_address        to instruction memory (always equals pc)
//   imem_instruction    combinational read data for imem_address
//   if_id_instruction   registered word for decode (0 is a NOP)
//   if_id_pc_plus1      registered address of the fetched word + 1
//   if_id_valid         IF/ID holds a real instruction
//   running             high while in RUN
//   fetch_count         number of words committed into IF/ID
module instruction_fetch #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 19,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               halt,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_instruction,
    output logic [INSTR_W-1:0] if_id_instruction,
    output logic [ADDR_W-1:0]  if_id_pc_plus1,
    output logic               if_id_valid,
    output logic               running,
    output logic [CNT_W-1:0]   fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  pc_plus1;
    logic [INSTR_W-1:0] instruction_next;
    logic [ADDR_W-1:0]  pc_plus1_next;
    logic               valid_next;
    logic [CNT_W-1:0]   count_next;
    logic               is_jmp;
    logic [ADDR_W-1:0]  jmp_target;

    // Absolute JMP is recognised straight off the memory output so the next
    // pc can follow it in the same cycle the JMP word is captured.
    assign is_jmp     = (imem_instruction[INSTR_W-1 -: 5] == 5'b11100);
    assign jmp_target = imem_instruction[ADDR_W-1:0];
    assign pc_plus1   = pc + ADDR_W'(1);

    assign imem_address = pc;
    assign running      = (state == RUN);

    // Next-state and datapath decisions. Everything holds by default; any
    // non-fetching cycle (IDLE, HALT, redirect bubble) loads a NOP with
    // valid low, while if_id_pc_plus1 keeps its last value.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instruction_next = if_id_instruction;
        pc_plus1_next    = if_id_pc_plus1;
        valid_next       = if_id_valid;
        count_next       = fetch_count;

        case (state)
            IDLE: begin
                instruction_next = '0;
                valid_next       = 1'b0;
                if (start) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                if (halt) begin
                    // halt beats stall; a redirect in the same cycle still
                    // lands so resuming continues from the branch target.
                    state_next       = HALT;
                    instruction_next = '0;
                    valid_next       = 1'b0;
                    if (redirect_valid) begin
                        pc_next = redirect_target;
                    end
                end else if (redirect_valid) begin
                    pc_next          = redirect_target;
                    instruction_next = '0;
                    valid_next       = 1'b0;
                end else if (!stall) begin
                    instruction_next = imem_instruction;
                    pc_plus1_next    = pc_plus1;
                    valid_next       = 1'b1;
                    count_next       = fetch_count + CNT_W'(1);
                    pc_next          = is_jmp ? jmp_target : pc_plus1;
                end
            end

            HALT: begin
                instruction_next = '0;
                valid_next       = 1'b0;
                if (halt) begin
                    state_next = HALT;
                end else if (redirect_valid) begin
                    state_next = RUN;
                    pc_next    = redirect_target;
                end else if (start) begin
                    state_next = RUN;
                end
            end

            default: begin
                state_next       = IDLE;
                instruction_next = '0;
                valid_next       = 1'b0;
            end
        endcase
    end

    // State and pipeline registers; reset clears everything immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            pc                <= '0;
            if_id_instruction <= '0;
            if_id_pc_plus1    <= '0;
            if_id_valid       <= 1'b0;
            fetch_count       <= '0;
        end else begin
            state             <= state_next;
            pc                <= pc_next;
            if_id_instruction <= instruction_next;
            if_id_pc_plus1    <= pc_plus1_next;
            if_id_valid       <= valid_next;
            fetch_count       <= count_next;
        end
    end

endmodule
